// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory request/response, decode handshake,
// redirect and halt control. master = fetch unit, slave = memory/decode side.
interface fetch_if #(
    parameter int unsigned ABITS = 32,
    parameter int unsigned DBITS = 32
);
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [ABITS-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [DBITS-1:0] imem_rsp_data;
    logic             dec_valid;
    logic             dec_ready;
    logic [DBITS-1:0] dec_inst;
    logic [ABITS-1:0] dec_pc;
    logic             redirect;
    logic [ABITS-1:0] redirect_pc;
    logic             halt;
    logic             halted;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc, halted,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready, redirect,
               redirect_pc, halt
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc, halted,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready, redirect,
               redirect_pc, halt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited word requests,
// queues returned words with their PCs for decode and squashes stale data on redirect.
module fetch_unit #(
    parameter int unsigned      ABITS    = 32,
    parameter int unsigned      DBITS    = 32,
    parameter int unsigned      DEPTH    = 2,
    parameter logic [ABITS-1:0] RESET_PC = '0
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned CW1 = CW + 1;

    typedef enum logic [1:0] {StIdle, StFetch, StHalted} state_e;

    state_e           state_q, state_d;
    logic [ABITS-1:0] fpc_q;
    logic [CW-1:0]    out_cnt_q, drop_cnt_q, q_cnt_q;

    // Address tags for in-flight requests, consumed one per response (dropped or not)
    logic [ABITS-1:0] tag_mem_q [DEPTH];
    logic [PW-1:0]    tag_wr_q, tag_rd_q;

    logic [DBITS-1:0] inst_mem_q [DEPTH];
    logic [ABITS-1:0] pc_mem_q   [DEPTH];
    logic [PW-1:0]    q_wr_q, q_rd_q;

    logic          pop, accept, push, drop;
    logic [CW-1:0] credit;

    assign pop    = bus.dec_valid & bus.dec_ready;
    // Out-of-range credit is impossible: a pop implies q_cnt >= 1.
    assign credit = out_cnt_q + q_cnt_q - CW'(pop);
    assign accept = bus.imem_req_valid & bus.imem_req_ready;
    assign drop   = bus.imem_rsp_valid & (drop_cnt_q != '0);
    assign push   = bus.imem_rsp_valid & (drop_cnt_q == '0) & ~bus.redirect;

    assign bus.imem_req_valid = (state_q == StFetch) & ~bus.halt & ~bus.redirect &
                                (CW1'(credit) < CW1'(DEPTH));
    assign bus.imem_req_addr  = fpc_q;
    assign bus.dec_valid      = (q_cnt_q != '0);
    assign bus.dec_inst       = inst_mem_q[q_rd_q];
    assign bus.dec_pc         = pc_mem_q[q_rd_q];
    assign bus.halted         = (state_q == StHalted);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (bus.halt && out_cnt_q == '0) state_d = StHalted;
            StHalted: if (!bus.halt) state_d = StFetch;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            fpc_q      <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            q_cnt_q    <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            q_wr_q     <= '0;
            q_rd_q     <= '0;
            tag_mem_q  <= '{default: '0};
            inst_mem_q <= '{default: '0};
            pc_mem_q   <= '{default: '0};
        end else begin
            state_q   <= state_d;
            out_cnt_q <= out_cnt_q + CW'(accept) - CW'(bus.imem_rsp_valid);
            if (accept) begin
                tag_mem_q[tag_wr_q] <= fpc_q;
                tag_wr_q            <= tag_wr_q + PW'(1);
            end
            if (bus.imem_rsp_valid) tag_rd_q <= tag_rd_q + PW'(1);

            if (bus.redirect) begin
                // Everything still in flight, minus a response landing now, is stale.
                fpc_q      <= bus.redirect_pc;
                drop_cnt_q <= out_cnt_q - CW'(bus.imem_rsp_valid);
                q_cnt_q    <= '0;
                q_wr_q     <= '0;
                q_rd_q     <= '0;
            end else begin
                if (accept) fpc_q <= fpc_q + ABITS'(1);
                if (drop) drop_cnt_q <= drop_cnt_q - CW'(1);
                if (push) begin
                    inst_mem_q[q_wr_q] <= bus.imem_rsp_data;
                    pc_mem_q[q_wr_q]   <= tag_mem_q[tag_rd_q];
                    q_wr_q             <= q_wr_q + PW'(1);
                end
                if (pop) q_rd_q <= q_rd_q + PW'(1);
                q_cnt_q <= q_cnt_q + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers requests, stimulus pushes the
// expected decode stream, and a negedge monitor checks requests and decode handoffs.
module tb_fetch_unit;
    logic clk;
    logic rst;

    fetch_if #(.ABITS(32), .DBITS(32)) bus ();

    fetch_unit #(
        .ABITS(32), .DBITS(32), .DEPTH(2), .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int n_acc = 0;
    int n_pop = 0;
    int first_acc = -1;
    int first_pop = -1;
    int last_rsp_cyc = 0;

    logic [31:0] exp_fpc = 32'h0;
    logic [31:0] exp_pc[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A00_00A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] v;
        v = start;
        for (int i = 0; i < n; i++) begin
            exp_pc.push_back(v);
            v = v + 32'h1;
        end
    endtask

    // Stop fetching, let everything drain, and confirm the next undelivered pc is the next
    // fetch address (nothing lost, nothing duplicated).
    task automatic drain_and_close();
        int n;
        bus.halt      = 1'b1;
        bus.dec_ready = 1'b1;
        n = 0;
        while (!(bus.halted && !bus.dec_valid) && n < 60) begin
            step();
            n++;
        end
        check1("drain_timeout", n < 60, 1'b1);
        check("no_lost_pc", (exp_pc.size() > 0) ? exp_pc[0] : 32'hDEAD_BEEF, exp_fpc);
        exp_pc.delete();
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory: one response per accepted request, in order, lat cycles after acceptance
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(pend_addr.pop_front());
                void'(pend_due.pop_front());
                last_rsp_cyc = cyc;
            end else begin
                bus.imem_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        logic        hold_v;
        logic        redir_prev;
        logic        halted_prev;
        logic [31:0] held_pc;
        logic [31:0] held_inst;
        logic [31:0] e;
        hold_v      = 1'b0;
        redir_prev  = 1'b0;
        halted_prev = 1'b0;
        held_pc     = '0;
        held_inst   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    check("req_addr", bus.imem_req_addr, exp_fpc);
                    exp_fpc = exp_fpc + 32'h1;
                    pend_addr.push_back(bus.imem_req_addr);
                    pend_due.push_back(cyc + lat);
                    n_acc++;
                    if (first_acc < 0) first_acc = cyc;
                end
                if (bus.redirect) check1("no_req_on_redirect", bus.imem_req_valid, 1'b0);
                if (hold_v && !redir_prev) begin
                    check1("hold_valid", bus.dec_valid, 1'b1);
                    check("hold_pc", bus.dec_pc, held_pc);
                    check("hold_inst", bus.dec_inst, held_inst);
                end
                if (bus.dec_valid && bus.dec_ready) begin
                    if (exp_pc.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dec_unexpected: got pc %h expected no delivery", bus.dec_pc);
                    end else begin
                        e = exp_pc.pop_front();
                        check("dec_pc", bus.dec_pc, e);
                        check("dec_inst", bus.dec_inst, mem_word(e));
                    end
                    n_pop++;
                    if (first_pop < 0) first_pop = cyc;
                end
                if (bus.halted) begin
                    check("halted_with_inflight", pend_addr.size(), 32'd0);
                    if (!halted_prev)
                        check1("halted_rise_gap",
                               (cyc - last_rsp_cyc >= 1) && (cyc - last_rsp_cyc <= 2), 1'b1);
                end
                hold_v      = bus.dec_valid && !bus.dec_ready;
                held_pc     = bus.dec_pc;
                held_inst   = bus.dec_inst;
                redir_prev  = bus.redirect;
                halted_prev = bus.halted;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [31:0] head;
        rst                = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.dec_ready      = 1'b1;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        step();
        step();
        check1("rst_req_valid", bus.imem_req_valid, 1'b0);
        check("rst_req_addr", bus.imem_req_addr, 32'h0);
        check1("rst_dec_valid", bus.dec_valid, 1'b0);
        check("rst_dec_inst", bus.dec_inst, 32'h0);
        check("rst_dec_pc", bus.dec_pc, 32'h0);
        check1("rst_halted", bus.halted, 1'b0);

        // Streaming at 1 inst/cycle, then a decode stall
        exp_fpc = 32'h0;
        push_stream(32'h0, 40);
        rst = 1'b0;
        step();
        step();
        step();
        for (int i = 0; i < 7; i++) begin
            check1("stream_dec_valid", bus.dec_valid, 1'b1);
            step();
        end
        bus.dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check1("stall_credit", (n_acc - n_pop) <= 2, 1'b1);
        end
        bus.dec_ready = 1'b1;
        repeat (6) step();
        drain_and_close();
        check("first_dec_latency", 32'(first_pop - first_acc), 32'd2);

        // 3-cycle memory, redirect with two stale requests in flight
        lat      = 3;
        bus.halt = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!(pend_addr.size() == 2 && !bus.imem_rsp_valid) && n < 20);
        check1("inflight2_timeout", n < 20, 1'b1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        exp_fpc         = 32'h40;
        push_stream(32'h40, 16);
        step();
        bus.redirect = 1'b0;
        repeat (10) step();
        drain_and_close();

        // Redirect coinciding with an arriving response and a decode pop
        lat      = 1;
        push_stream(exp_fpc, 20);
        bus.halt = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!(n >= 4 && bus.imem_rsp_valid && bus.dec_valid) && n < 30);
        check1("rsp_pop_timeout", n < 30, 1'b1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h80;
        head            = exp_pc[0];
        exp_pc.delete();
        exp_pc.push_back(head);
        push_stream(32'h80, 16);
        exp_fpc = 32'h80;
        step();
        bus.redirect = 1'b0;
        repeat (6) step();
        drain_and_close();

        // Redirect while halted, then toggling req_ready across the address wrap
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        exp_fpc         = 32'hFFFF_FFFE;
        exp_pc.push_back(32'hFFFF_FFFE);
        exp_pc.push_back(32'hFFFF_FFFF);
        push_stream(32'h0, 10);
        step();
        bus.redirect = 1'b0;
        check1("halted_after_redirect", bus.halted, 1'b1);
        bus.halt = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bus.imem_req_ready = (i % 2 == 0);
            step();
        end
        bus.imem_req_ready = 1'b1;
        drain_and_close();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
